// File: rtl/move_input_conditioner_pkg.sv
// Shared types and default timing for the button front-end and the movement controller.
// Direction vectors throughout are ordered {right,left,down,up}.
package move_input_conditioner_pkg;

  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;

  typedef enum logic [1:0] {IDLE, FIRST, DELAY, REPEAT} state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms at 100 MHz
  localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 250 ms before auto-repeat
  localparam int DEF_REPEAT_PERIOD   = 2_500_000;   // 25 ms between repeats
  localparam int DEF_CNT_W           = 25;

  function automatic dir_t resolve_dir(input logic [3:0] lvl);
    if (lvl[3]) return RIGHT;
    if (lvl[2]) return LEFT;
    if (lvl[0]) return UP;
    if (lvl[1]) return DOWN;
    return NONE;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] oh;
    case (d)
      UP:      oh = 4'b0001;
      DOWN:    oh = 4'b0010;
      LEFT:    oh = 4'b0100;
      RIGHT:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/move_input_conditioner_button_debounce.sv
// Two-flop synchroniser plus stable-run counter for one raw button.
// Accepted level follows the pin after 2 sync cycles plus DEBOUNCE_CYCLES stable cycles.
module move_input_conditioner_button_debounce
  import move_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  logic             sync0_q, sync1_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised pin disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync1_q != level_q) begin
      if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= btn;
      sync1_q <= sync0_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Debounced, priority-resolved direction levels plus a move_tick strobe with auto-repeat.
// Direction outputs lag the accepted levels by 1 cycle; the first tick follows 1 cycle later.
module move_input_conditioner
  import move_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       move_tick,
  output logic [3:0] pressed
);

  logic [3:0] raw;
  logic [3:0] lvl;
  dir_t       dir;

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    move_input_conditioner_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (raw[i]),
      .level(lvl[i])
    );
  end

  assign dir = resolve_dir(lvl);

  state_t           state_q, state_d;
  dir_t             lat_q, lat_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic             tick_q, tick_d;
  logic [3:0]       dir_oh_q, dir_oh_d;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    rc_d     = rc_q;
    tick_d   = 1'b0;
    dir_oh_d = dir_onehot(dir);
    if (state_q != IDLE && dir == NONE) begin
      state_d = IDLE;
      rc_d    = '0;
    end else if (state_q != IDLE && dir != lat_q) begin
      lat_d   = dir;
      state_d = FIRST;
      rc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dir != NONE) begin
            lat_d   = dir;
            state_d = FIRST;
            rc_d    = '0;
          end
        end
        FIRST: begin
          tick_d  = 1'b1;
          rc_d    = '0;
          state_d = DELAY;
        end
        DELAY: begin
          // Enter REPEAT primed so the first repeat lands REPEAT_DELAY+1 after the first tick.
          if (rc_q >= CNT_W'(REPEAT_DELAY - 1)) begin
            rc_d    = CNT_W'(REPEAT_PERIOD - 1);
            state_d = REPEAT;
          end else begin
            rc_d = rc_q + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (rc_q >= CNT_W'(REPEAT_PERIOD - 1)) begin
            tick_d = 1'b1;
            rc_d   = '0;
          end else begin
            rc_d = rc_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lat_q    <= NONE;
      rc_q     <= '0;
      tick_q   <= 1'b0;
      dir_oh_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      rc_q     <= rc_d;
      tick_q   <= tick_d;
      dir_oh_q <= dir_oh_d;
    end
  end

  assign up        = dir_oh_q[0];
  assign down      = dir_oh_q[1];
  assign left      = dir_oh_q[2];
  assign right     = dir_oh_q[3];
  assign move_tick = tick_q;
  assign pressed   = lvl;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner: directed scenarios with literal expectations plus
// randomized button traffic, all compared every cycle against a hold-age reference model.
module tb_move_input_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic up, down, left, right, move_tick;
  logic [3:0] pressed;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .move_tick(move_tick),
    .pressed  (pressed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int tick_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] prio(input logic [3:0] a);
    if (a[3]) return 4'b1000;
    if (a[2]) return 4'b0100;
    if (a[0]) return 4'b0001;
    if (a[1]) return 4'b0010;
    return 4'b0000;
  endfunction

  // Tick due at k edges after the first tick of an unchanged hold.
  function automatic bit due(input int k);
    return (k == 0) || (k >= RD + 1 && ((k - RD - 1) % RP) == 0);
  endfunction

  function automatic bit has_tick(input int t);
    foreach (tick_q[i]) if (tick_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: pin -> 2-edge delay -> accepted once the last DEB synced samples all
  // disagree with it; ticks derived from how long the resolved direction has been unchanged.
  logic [3:0] m_p0, m_p1, m_acc, m_dprev, m_out;
  logic [3:0] m_win [DEB];
  int         m_age;
  bit         m_tick;

  always @(posedge clk) begin : model
    logic [3:0] used, dnew;
    bit flip;
    cyc++;
    if (!rst_n) begin
      m_p0 = '0; m_p1 = '0; m_acc = '0; m_dprev = '0; m_out = '0;
      m_age = 0; m_tick = 1'b0;
      for (int i = 0; i < DEB; i++) m_win[i] = '0;
    end else begin
      used = m_p1;
      m_p1 = m_p0;
      m_p0 = {btn_right, btn_left, btn_down, btn_up};
      for (int i = DEB - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = used;
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_win[i][b] == m_acc[b]) flip = 1'b0;
        if (flip) m_acc[b] = ~m_acc[b];
      end
      m_tick = (m_dprev != 4'b0000) && (m_age >= 1) && due(m_age - 1);
      m_out  = m_dprev;
      dnew   = prio(m_acc);
      if (dnew != m_dprev) m_age = 0;
      else if (m_age < 100000) m_age++;
      m_dprev = dnew;
    end
    #1;
    check("dir_levels", int'({right, left, down, up}), int'(m_out));
    check("move_tick", int'(move_tick), int'(m_tick));
    check("pressed", int'(pressed), int'(m_acc));
    if (move_tick) tick_q.push_back(cyc);
  end

  task automatic set_btns(input logic [3:0] v);
    @(negedge clk);
    {btn_right, btn_left, btn_down, btn_up} = v;
  endtask

  // Counts edges from now until move_tick (or right) is seen, bounded.
  task automatic edges_until(input bit want_right, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      n++;
      if (want_right ? right : move_tick) break;
    end
  endtask

  initial begin : stim
    int n, tb, c, t0, d;
    // Reset with every button held
    rst_n = 1'b0;
    {btn_right, btn_left, btn_down, btn_up} = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({up, down, left, right, move_tick, pressed}), 0);
    rst_n = 1'b1;
    edges_until(1'b1, 40, n);
    check("right_latency_after_reset", n, 7);
    @(posedge clk); #2;
    check("first_tick_after_right", int'(move_tick), 1);
    set_btns(4'h0);
    repeat (20) @(negedge clk);

    // Bouncing left button
    tb = tick_q.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_left = ((i % 4) < 2);
    end
    check("bounce_ticks", tick_q.size() - tb, 0);
    tb = tick_q.size();
    set_btns(4'b0100);
    repeat (14) @(negedge clk);
    check("bounce_stable_ticks", tick_q.size() - tb, 1);
    check("bounce_left_level", int'({right, left, down, up}), 4'b0100);
    set_btns(4'h0);
    repeat (20) @(negedge clk);

    // Hold up: ticks at t0, t0+11, t0+14, t0+17
    tb = tick_q.size();
    set_btns(4'b0001);
    repeat (40) @(negedge clk);
    check("hold_tick_count_ge4", int'(tick_q.size() - tb >= 4), 1);
    if (tick_q.size() - tb >= 4) begin
      check("hold_gap1", tick_q[tb+1] - tick_q[tb], 11);
      check("hold_gap2", tick_q[tb+2] - tick_q[tb+1], 3);
      check("hold_gap3", tick_q[tb+3] - tick_q[tb+2], 3);
    end
    check("hold_dirs", int'({right, left, down, up}), 4'b0001);

    // Right pressed during the up hold
    set_btns(4'b1001);
    edges_until(1'b1, 40, n);
    c = cyc;
    repeat (15) @(negedge clk);
    check("switch_immediate_tick", int'(has_tick(c + 1)), 1);
    check("switch_restart_repeat", int'(has_tick(c + 12)), 1);
    check("switch_dirs", int'({right, left, down, up}), 4'b1000);
    set_btns(4'h0);
    repeat (20) @(negedge clk);

    // Left and down together, then release down
    tb = tick_q.size();
    set_btns(4'b0110);
    repeat (12) @(negedge clk);
    check("ld_pressed", int'(pressed), 4'b0110);
    check("ld_dirs", int'({right, left, down, up}), 4'b0100);
    set_btns(4'b0100);
    repeat (30) @(negedge clk);
    check("ld_pressed_after_release", int'(pressed), 4'b0100);
    check("ld_tick_seen", int'(tick_q.size() > tb), 1);
    if (tick_q.size() > tb) begin
      t0 = tick_q[tb];
      for (int i = tb + 1; i < tick_q.size(); i++) begin
        d = tick_q[i] - t0;
        check("ld_tick_schedule", int'(d >= 11 && ((d - 11) % 3) == 0), 1);
      end
    end

    // Reset while left is repeating
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midhold_reset_outputs", int'({up, down, left, right, move_tick, pressed}), 0);
    rst_n = 1'b1;
    edges_until(1'b0, 60, n);
    check("tick_latency_after_reset", n, 8);
    set_btns(4'h0);
    repeat (20) @(negedge clk);

    // Random traffic with occasional short resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) btn_up    = ~btn_up;
      if ($urandom_range(0, 29) == 0) btn_down  = ~btn_down;
      if ($urandom_range(0, 29) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 29) == 0) btn_right = ~btn_right;
      rst_n = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
